// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: coin denominations, their values and FSM states.
package change_pkg;

    typedef enum logic [1:0] {
        C50 = 2'd0,
        C10 = 2'd1,
        C5  = 2'd2,
        C1  = 2'd3
    } coin_t;

    // Indexed by coin_t; ordered largest first so index order is greedy order.
    localparam logic [7:0] DENOM_VAL [4] = '{8'd50, 8'd10, 8'd5, 8'd1};

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// Four saturating coin counters with a refill port and a single-coin decrement port.
module coin_inventory #(
    parameter int CNT_W    = 8,
    parameter int INIT_CNT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               refill_valid,
    input  logic [1:0]         refill_type,
    input  logic [7:0]         refill_cnt,
    input  logic               dec_valid,
    input  logic [1:0]         dec_type,
    output logic [4*CNT_W-1:0] cnt,
    output logic [3:0]         nonzero
);

    localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic [CNT_W-1:0] cnt_q [4];

    // Refill and decrement are combined before saturating, so a same-cycle pair nets out correctly.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cur,
        input logic             add_en,
        input logic [7:0]       add,
        input logic             sub_en
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(cur) + (add_en ? SUM_W'(add) : SUM_W'(0))
            - ((sub_en && cur != '0) ? SUM_W'(1) : SUM_W'(0));
        return (s > SUM_W'(MAX_CNT)) ? MAX_CNT : CNT_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= CNT_W'(INIT_CNT);
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= next_cnt(cnt_q[i],
                                     refill_valid && (refill_type == 2'(i)),
                                     refill_cnt,
                                     dec_valid && (dec_type == 2'(i)));
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
        assign nonzero[g]            = |cnt_q[g];
    end

endmodule

// File: rtl/change_dispenser.sv
// Splits a change amount into 50/10/5/1 coins, one per hopper handshake, tracking inventory.
//
// state  | meaning
// IDLE   | waiting for a change request, chg_ready=1
// SELECT | choose largest affordable denomination that is in stock
// ISSUE  | coin offered on coin_valid/coin_type until the hopper accepts
// DONE   | one-cycle done pulse, request fully paid
// ERR    | one-cycle err pulse, remain_out shows the unpaid amount
module change_dispenser
    import change_pkg::*;
#(
    parameter int INIT_CNT = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               chg_valid,
    input  logic [7:0]         chg_amt,
    output logic               chg_ready,
    output logic               coin_valid,
    output logic [1:0]         coin_type,
    input  logic               coin_ready,
    output logic               done,
    output logic               err,
    output logic [7:0]         remain_out,
    input  logic               refill_valid,
    input  logic [1:0]         refill_type,
    input  logic [7:0]         refill_cnt,
    output logic [4*CNT_W-1:0] inv_cnt
);

    state_t     state;
    logic [7:0] remaining;
    logic [7:0] rem_after;
    logic [3:0] inv_nz;
    logic       hs;
    logic       sel_ok;
    coin_t      sel_type;

    assign chg_ready = (state == IDLE) && !rst;
    assign hs        = (state == ISSUE) && coin_valid && coin_ready;
    assign rem_after = remaining - DENOM_VAL[coin_type];

    // Scanning smallest to largest leaves the largest qualifying denomination selected.
    always_comb begin
        sel_ok   = 1'b0;
        sel_type = C1;
        for (int i = 3; i >= 0; i--) begin
            if (inv_nz[i] && (DENOM_VAL[i] <= remaining)) begin
                sel_ok   = 1'b1;
                sel_type = coin_t'(2'(i));
            end
        end
    end

    coin_inventory #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_inv (
        .clk          (clk),
        .rst          (rst),
        .refill_valid (refill_valid),
        .refill_type  (refill_type),
        .refill_cnt   (refill_cnt),
        .dec_valid    (hs),
        .dec_type     (coin_type),
        .cnt          (inv_cnt),
        .nonzero      (inv_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            coin_valid <= 1'b0;
            coin_type  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            remain_out <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            remain_out <= '0;
            case (state)
                IDLE: begin
                    if (chg_valid) begin
                        if (chg_amt != '0) begin
                            remaining <= chg_amt;
                            state     <= SELECT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SELECT: begin
                    if (sel_ok) begin
                        coin_type  <= sel_type;
                        coin_valid <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        err        <= 1'b1;
                        remain_out <= remaining;
                        state      <= ERR;
                    end
                end
                ISSUE: begin
                    if (coin_ready) begin
                        coin_valid <= 1'b0;
                        remaining  <= rem_after;
                        if (rem_after == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed vector table, corner sequences, random requests.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst;
    logic        chg_valid;
    logic [7:0]  chg_amt;
    logic        chg_ready;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic        coin_ready;
    logic        done;
    logic        err;
    logic [7:0]  remain_out;
    logic        refill_valid;
    logic [1:0]  refill_type;
    logic [7:0]  refill_cnt;
    logic [31:0] inv_cnt;

    int checks   = 0;
    int failures = 0;
    int m_inv [4];
    localparam int DEN [4] = '{50, 10, 5, 1};

    typedef struct {
        int          amt;
        int          stall;
        string       seq;
        bit          e;
        int          rem;
        int          lat;
        logic [31:0] inv;
    } vec_t;
    vec_t vecs [11];

    change_dispenser dut (
        .clk          (clk),
        .rst          (rst),
        .chg_valid    (chg_valid),
        .chg_amt      (chg_amt),
        .chg_ready    (chg_ready),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .coin_ready   (coin_ready),
        .done         (done),
        .err          (err),
        .remain_out   (remain_out),
        .refill_valid (refill_valid),
        .refill_type  (refill_type),
        .refill_cnt   (refill_cnt),
        .inv_cnt      (inv_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic string short(input string s);
        return (s.len() > 60) ? s.substr(0, 59) : s;
    endfunction

    function automatic logic [31:0] pack_inv();
        return {8'(m_inv[3]), 8'(m_inv[2]), 8'(m_inv[1]), 8'(m_inv[0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=\"%s\"(len %0d) required=\"%s\"(len %0d)",
                     name, short(act), act.len(), short(exp), exp.len());
        end
    endtask

    // Greedy payout from the spec rules, consuming the model inventory.
    function automatic void model_req(input int amt, output string seq, output bit e, output int rem);
        int pick;
        rem = amt;
        seq = "";
        e   = 1'b0;
        while (rem > 0) begin
            pick = -1;
            for (int d = 0; d < 4; d++)
                if (pick < 0 && DEN[d] <= rem && m_inv[d] > 0) pick = d;
            if (pick < 0) begin
                e = 1'b1;
                break;
            end
            seq = {seq, $sformatf("%0d", pick)};
            rem -= DEN[pick];
            m_inv[pick]--;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; chg_valid = 1'b0; coin_ready = 1'b0; refill_valid = 1'b0;
        @(negedge clk);
        check("rst_chg_ready", chg_ready, 0);
        check("rst_coin_valid", coin_valid, 0);
        check("rst_done_err", {done, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) m_inv[d] = 8;
        check("post_rst_inv", inv_cnt, 32'h08080808);
        check("post_rst_outs", {coin_valid, coin_type, done, err, remain_out}, 0);
        check("post_rst_ready", chg_ready, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!chg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_chg_ready", chg_ready, 1);
    endtask

    task automatic refill(input int t, input int c);
        refill_valid = 1'b1; refill_type = 2'(t); refill_cnt = 8'(c);
        @(negedge clk);
        refill_valid = 1'b0;
        m_inv[t] = (m_inv[t] + c > 255) ? 255 : m_inv[t] + c;
    endtask

    task automatic do_req(input int amt, input int stall, input bit rnd,
                          output string seq, output bit got_err, output int rem, output int lat);
        int   cyc = 1;
        int   stall_left = stall;
        bit   fin = 1'b0;
        bit   held_v = 1'b0;
        logic [1:0] held;
        bit   r;
        seq = ""; got_err = 1'b0; rem = 0; lat = -1;
        wait_ready();
        chg_valid = 1'b1; chg_amt = 8'(amt); coin_ready = 1'b0;
        @(negedge clk);
        chg_valid = 1'b0;
        while (!fin && cyc <= 3000) begin
            if (done) begin
                lat = cyc; fin = 1'b1;
            end else if (err) begin
                got_err = 1'b1; rem = remain_out; lat = cyc; fin = 1'b1;
            end else begin
                if (held_v) check("stall_hold", {coin_valid, coin_type}, {1'b1, held});
                if (coin_valid) begin
                    if (rnd) r = ($urandom_range(0, 3) != 0);
                    else     r = (stall_left == 0);
                    if (!rnd && stall_left > 0) stall_left--;
                    coin_ready = r;
                    if (r) begin
                        seq = {seq, $sformatf("%0d", coin_type)};
                        held_v = 1'b0;
                    end else begin
                        held = coin_type; held_v = 1'b1;
                    end
                end else begin
                    coin_ready = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        coin_ready = 1'b0;
        check("req_finished", fin, 1);
        @(negedge clk);
        check("pulse_one_cycle", {done, err}, 0);
        check("ready_after", chg_ready, 1);
    endtask

    // Single-coin request whose handshake coincides with a refill.
    task automatic hs_refill(input int amt, input int ctype, input int rtype, input int rcnt);
        int n = 0;
        wait_ready();
        chg_valid = 1'b1; chg_amt = 8'(amt); coin_ready = 1'b0;
        @(negedge clk);
        chg_valid = 1'b0;
        while (!coin_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("hsr_offer", coin_valid, 1);
        check("hsr_type", coin_type, ctype);
        coin_ready = 1'b1; refill_valid = 1'b1; refill_type = 2'(rtype); refill_cnt = 8'(rcnt);
        @(negedge clk);
        coin_ready = 1'b0; refill_valid = 1'b0;
        check("hsr_done", done, 1);
        m_inv[rtype] += rcnt;
        m_inv[ctype] -= 1;
        for (int d = 0; d < 4; d++) if (m_inv[d] > 255) m_inv[d] = 255;
        check("hsr_inv", inv_cnt, pack_inv());
        @(negedge clk);
    endtask

    task automatic set_vec(input int i, input int amt, input int stall, input string seq,
                           input bit e, input int rem, input int lat, input logic [31:0] inv);
        vecs[i].amt = amt; vecs[i].stall = stall; vecs[i].seq = seq; vecs[i].e = e;
        vecs[i].rem = rem; vecs[i].lat = lat; vecs[i].inv = inv;
    endtask

    initial begin
        string seq, mseq;
        bit    e, me;
        int    rem, mrem, lat, n;

        // inv packing: [31:24]=1s, [23:16]=5s, [15:8]=10s, [7:0]=50s
        set_vec(0,  17, 0, "1233",   0, 0, 9,  32'h06070708);
        set_vec(1,   0, 0, "",       0, 0, 1,  32'h06070708);
        set_vec(2,  60, 3, "01",     0, 0, 8,  32'h06070607);
        set_vec(3,  40, 0, "1111",   0, 0, 9,  32'h06070207);
        set_vec(4,  20, 0, "11",     0, 0, 5,  32'h06070007);
        set_vec(5,  20, 0, "2222",   0, 0, 9,  32'h06030007);
        set_vec(6,  15, 0, "222",    0, 0, 7,  32'h06000007);
        set_vec(7,   6, 0, "333333", 0, 0, 13, 32'h00000007);
        set_vec(8,  53, 0, "0",      1, 3, 4,  32'h00000006);
        set_vec(9,   4, 0, "",       1, 4, 2,  32'h00000006);
        set_vec(10, 60, 0, "0",      1, 10, 4, 32'h00000005);

        chg_amt = '0; refill_type = '0; refill_cnt = '0;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].amt, vecs[i].stall, 1'b0, seq, e, rem, lat);
            check_s($sformatf("vec%0d_seq", i), seq, vecs[i].seq);
            check($sformatf("vec%0d_err", i), e, vecs[i].e);
            check($sformatf("vec%0d_rem", i), rem, vecs[i].rem);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_inv", i), inv_cnt, vecs[i].inv);
        end

        // Refill saturation and same-cycle refill/decrement.
        do_reset();
        hs_refill(10, 1, 1, 4);
        check("inv10_net", inv_cnt[15:8], 11);
        refill(3, 250);
        check("inv1_sat", inv_cnt[31:24], 255);
        hs_refill(1, 3, 3, 1);
        check("inv1_sat_net", inv_cnt[31:24], 255);

        // Reset while a coin is stalled in ISSUE aborts silently.
        wait_ready();
        chg_valid = 1'b1; chg_amt = 8'd17; coin_ready = 1'b0;
        @(negedge clk);
        chg_valid = 1'b0;
        n = 0;
        while (!coin_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("midrst_offer", {coin_valid, coin_type}, {1'b1, 2'd1});
        do_reset();
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || err || coin_valid) n++;
        end
        check("midrst_quiet", n, 0);

        // Random requests against the greedy model, refilling between requests.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                refill($urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 40));
            rem = $urandom_range(0, 255);
            model_req(rem, mseq, me, mrem);
            do_req(rem, 0, 1'b1, seq, e, rem, lat);
            check_s($sformatf("rnd%0d_seq", i), seq, mseq);
            check($sformatf("rnd%0d_err", i), e, me);
            check($sformatf("rnd%0d_rem", i), rem, me ? mrem : 0);
            check($sformatf("rnd%0d_inv", i), inv_cnt, pack_inv());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
